// File: rtl/neosd_pkg.sv
// Shared constants for the neosd DMA engine: neosd register map, CTRL flag
// positions, DMA register map and the DMA sequencer state type.
package neosd_pkg;

  // neosd register offsets relative to NEOSD_BASE
  localparam logic [31:0] NEOSD_INFO = 32'h00;
  localparam logic [31:0] NEOSD_CTRL = 32'h04;
  localparam logic [31:0] NEOSD_CMD  = 32'h08;
  localparam logic [31:0] NEOSD_ARG  = 32'h0C;
  localparam logic [31:0] NEOSD_RESP = 32'h10;
  localparam logic [31:0] NEOSD_DATA = 32'h14;

  // neosd CTRL status bits
  localparam int unsigned FLAG_DAT_DATA = 17;
  localparam int unsigned CTRL_CRCERR   = 14;

  // DMA register offsets (s_adr_i[3:0])
  localparam logic [3:0] DMA_CTRL  = 4'h0;
  localparam logic [3:0] DMA_MADDR = 4'h4;
  localparam logic [3:0] DMA_WCNT  = 4'h8;

  // DMA CTRL bits
  localparam int unsigned DMA_START = 0;
  localparam int unsigned DMA_DIR   = 1;
  localparam int unsigned DMA_IRQEN = 2;
  localparam int unsigned DMA_ABORT = 3;
  localparam int unsigned DMA_BUSY  = 8;
  localparam int unsigned DMA_DONE  = 9;
  localparam int unsigned DMA_ERR   = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_CHK,
    ST_SRC,
    ST_DST,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } dma_state_t;

endpackage

// File: rtl/neosd_dma_wbm.sv
// Single-access classic Wishbone master with ack timeout. The sequencer holds
// req; one access is launched when the master is idle and no done/err pulse
// is outstanding, and exactly one done or err pulse reports its completion.
module neosd_dma_wbm #(
  parameter int unsigned TMO_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdat,
  output logic        done,
  output logic        err,
  output logic [31:0] rdat,
  output logic [31:0] m_adr,
  output logic [31:0] m_wdat,
  output logic        m_we,
  output logic        m_stb,
  input  logic [31:0] m_rdat,
  input  logic        m_ack,
  input  logic        m_err
);

  logic [TMO_W-1:0] tmo;
  logic             start;
  logic             timeout;

  assign start   = req & ~m_stb & ~done & ~err;
  assign timeout = (tmo == '1);

  // Access engine: strobe held until ack/err/timeout, err has priority over ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stb  <= 1'b0;
      m_we   <= 1'b0;
      m_adr  <= '0;
      m_wdat <= '0;
      tmo    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      rdat   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (m_stb) begin
        if (m_err || (timeout && !m_ack)) begin
          err   <= 1'b1;
          m_stb <= 1'b0;
          m_we  <= 1'b0;
        end else if (m_ack) begin
          done  <= 1'b1;
          rdat  <= m_rdat;
          m_stb <= 1'b0;
          m_we  <= 1'b0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else if (start) begin
        m_stb  <= 1'b1;
        m_we   <= we;
        m_adr  <= adr;
        m_wdat <= wdat;
        tmo    <= TMO_W'(1);
      end
    end
  end

endmodule

// File: rtl/neosd_dma.sv
// Wishbone DMA engine moving words between system memory and the neosd DATA
// register, paced by the neosd FLAG_DAT_DATA status bit.
module neosd_dma
  import neosd_pkg::*;
#(
  parameter logic [31:0] NEOSD_BASE = 32'hF000_0000,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TMO_W      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  input  logic        s_we_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic        irq_o
);

  dma_state_t       state, nxt;
  logic             dir, irq_en, busy, done, err, abort_pend;
  logic [31:2]      maddr;
  logic [CNT_W-1:0] wcnt;
  logic [31:0]      hold;

  logic             acc, wr;
  logic [3:0]       off;
  logic             start_cmd, start_go, abort_cmd, abort_any;
  logic             bus_req, bus_we, bus_done, bus_err;
  logic [31:0]      bus_adr, bus_wdat, bus_rdat;
  logic [31:0]      ctrl_rd;
  logic             unused;

  assign acc       = s_stb_i & s_cyc_i & ~s_ack_o;
  assign wr        = acc & s_we_i;
  assign off       = s_adr_i[3:0];
  assign start_cmd = wr && (off == DMA_CTRL) && s_dat_i[DMA_START] && !busy;
  assign start_go  = start_cmd && (wcnt != '0);
  assign abort_cmd = wr && (off == DMA_CTRL) && s_dat_i[DMA_ABORT] && busy;
  assign abort_any = abort_pend | abort_cmd;
  assign ctrl_rd   = {21'b0, err, done, busy, 5'b0, irq_en, dir, 1'b0};
  assign m_cyc_o   = m_stb_o;
  assign m_sel_o   = 4'hF;
  assign unused    = ^s_adr_i[31:4];

  neosd_dma_wbm #(.TMO_W(TMO_W)) u_wbm (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    (bus_req),
    .we     (bus_we),
    .adr    (bus_adr),
    .wdat   (bus_wdat),
    .done   (bus_done),
    .err    (bus_err),
    .rdat   (bus_rdat),
    .m_adr  (m_adr_o),
    .m_wdat (m_dat_o),
    .m_we   (m_we_o),
    .m_stb  (m_stb_o),
    .m_rdat (m_dat_i),
    .m_ack  (m_ack_i),
    .m_err  (m_err_i)
  );

  // Sequencer state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= nxt;
  end

  // Next-state: a pending abort is honoured only once no access is in flight
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: if (start_go) nxt = ST_POLL;
      ST_POLL: if (bus_err) nxt = ST_ERR;
               else if (bus_done) nxt = abort_any ? ST_ERR : ST_CHK;
      ST_CHK:  if (abort_any || bus_rdat[CTRL_CRCERR]) nxt = ST_ERR;
               else if (bus_rdat[FLAG_DAT_DATA]) nxt = ST_SRC;
               else nxt = ST_POLL;
      ST_SRC:  if (bus_err) nxt = ST_ERR;
               else if (bus_done) nxt = abort_any ? ST_ERR : ST_DST;
      ST_DST:  if (bus_err) nxt = ST_ERR;
               else if (bus_done) nxt = abort_any ? ST_ERR : ST_NEXT;
      ST_NEXT: if (abort_any) nxt = ST_ERR;
               else nxt = (wcnt == CNT_W'(1)) ? ST_DONE : ST_POLL;
      ST_DONE: nxt = ST_IDLE;
      ST_ERR:  nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Bus request for the access belonging to the current state
  always_comb begin
    bus_req  = 1'b0;
    bus_we   = 1'b0;
    bus_adr  = NEOSD_BASE + NEOSD_CTRL;
    bus_wdat = hold;
    unique case (state)
      ST_POLL: bus_req = 1'b1;
      ST_SRC: begin
        bus_req = 1'b1;
        bus_adr = dir ? {maddr, 2'b00} : NEOSD_BASE + NEOSD_DATA;
      end
      ST_DST: begin
        bus_req = 1'b1;
        bus_we  = 1'b1;
        bus_adr = dir ? NEOSD_BASE + NEOSD_DATA : {maddr, 2'b00};
      end
      default: ;
    endcase
  end

  // Register file and job datapath; hardware flag sets are placed last so they win over W1C
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dir        <= 1'b0;
      irq_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      abort_pend <= 1'b0;
      maddr      <= '0;
      wcnt       <= '0;
      hold       <= '0;
    end else begin
      if (wr && off == DMA_CTRL) begin
        irq_en <= s_dat_i[DMA_IRQEN];
        if (!busy) dir <= s_dat_i[DMA_DIR];
        if (s_dat_i[DMA_DONE]) done <= 1'b0;
        if (s_dat_i[DMA_ERR])  err  <= 1'b0;
      end
      if (wr && off == DMA_MADDR && !busy) maddr <= s_dat_i[31:2];
      if (wr && off == DMA_WCNT && !busy)  wcnt  <= s_dat_i[CNT_W-1:0];
      if (start_cmd) begin
        if (wcnt == '0) done <= 1'b1;
        else begin
          busy       <= 1'b1;
          abort_pend <= 1'b0;
        end
      end
      if (abort_cmd) abort_pend <= 1'b1;
      if (state == ST_SRC && bus_done) hold <= bus_rdat;
      if (state == ST_NEXT) begin
        maddr <= maddr + 30'd1;
        wcnt  <= wcnt - CNT_W'(1);
      end
      if (state == ST_DONE) begin
        done       <= 1'b1;
        busy       <= 1'b0;
        abort_pend <= 1'b0;
      end
      if (state == ST_ERR) begin
        err        <= 1'b1;
        busy       <= 1'b0;
        abort_pend <= 1'b0;
      end
    end
  end

  // Slave port: ack one cycle after strobe, read data only alongside a read ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_ack_o <= 1'b0;
      s_dat_o <= '0;
    end else begin
      s_ack_o <= acc;
      s_dat_o <= '0;
      if (acc && !s_we_i) begin
        unique case (off)
          DMA_CTRL:  s_dat_o <= ctrl_rd;
          DMA_MADDR: s_dat_o <= {maddr, 2'b00};
          DMA_WCNT:  s_dat_o <= 32'(wcnt);
          default:   s_dat_o <= '0;
        endcase
      end
    end
  end

  // Registered interrupt level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= irq_en & (done | err);
  end

endmodule

// File: tb/tb_neosd_dma.sv
// Self-checking bench for neosd_dma: register table, directed job sequences and
// randomized jobs against a transfer-list reference model.
module tb_neosd_dma;
  import neosd_pkg::*;

  localparam logic [31:0] BASE  = 32'hF000_0000;
  localparam logic [31:0] DSRC  = 32'hDA7A_0000;
  localparam logic [31:0] A_CTL = BASE + 32'h04;
  localparam logic [31:0] A_DAT = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_adr = '0, s_dat = '0;
  logic        s_we = 1'b0, s_stb = 1'b0, s_cyc = 1'b0;
  logic        s_ack_o, m_we_o, m_stb_o, m_cyc_o, irq_o;
  logic [31:0] s_dat_o, m_adr_o, m_dat_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_rdat;
  logic        m_ack, m_err;

  // bench configuration (driven by the stimulus process only)
  int unsigned lat = 0, data_lat = 0, low_polls = 0;
  logic        crc_mode = 1'b0, mem_noack = 1'b0, clr = 1'b1;

  // slave-model observations (driven by the slave process only)
  int unsigned wait_cnt, n_poll, n_drd, n_dwr, n_mwr, n_dacc, first_data_poll;
  int unsigned cyc_cycles, stb_run, stb_run_max;
  logic [31:0] dwr_log [0:63];
  logic [31:0] mwr_adr [0:63];
  logic [31:0] mwr_dat [0:63];

  int unsigned n_pass = 0, n_total = 0;

  neosd_dma #(.NEOSD_BASE(BASE), .CNT_W(16), .TMO_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_adr_i(s_adr), .s_dat_i(s_dat), .s_we_i(s_we), .s_stb_i(s_stb), .s_cyc_i(s_cyc),
    .s_ack_o(s_ack_o), .s_dat_o(s_dat_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_dat_i(m_rdat), .m_ack_i(m_ack),
    .m_err_i(m_err), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return a ^ 32'h5A5A_3C3C;
  endfunction

  logic        is_ctl, is_dat, is_mem;
  int unsigned need_lat;
  assign is_ctl   = (m_adr_o == A_CTL);
  assign is_dat   = (m_adr_o == A_DAT);
  assign is_mem   = !is_ctl && !is_dat;
  assign need_lat = is_dat ? data_lat : lat;

  // Wishbone slave model: neosd CTRL/DATA plus pattern memory, with logging
  always @(posedge clk) begin
    if (clr) begin
      m_ack <= 1'b0; m_err <= 1'b0; m_rdat <= '0;
      wait_cnt <= 0; n_poll <= 0; n_drd <= 0; n_dwr <= 0; n_mwr <= 0;
      n_dacc <= 0; first_data_poll <= 0; cyc_cycles <= 0; stb_run <= 0; stb_run_max <= 0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      if (m_cyc_o) cyc_cycles <= cyc_cycles + 1;
      stb_run <= m_stb_o ? stb_run + 1 : 0;
      if (m_stb_o && (stb_run + 1 > stb_run_max)) stb_run_max <= stb_run + 1;
      if (m_stb_o && m_cyc_o && !m_ack && !m_err) begin
        if (wait_cnt < need_lat) wait_cnt <= wait_cnt + 1;
        else if (!(mem_noack && is_mem && m_we_o)) begin
          wait_cnt <= 0;
          m_ack    <= 1'b1;
          if (is_ctl) begin
            m_rdat <= (crc_mode ? 32'h0000_4000 : 32'h0) |
                      ((n_poll >= low_polls) ? 32'h0002_0000 : 32'h0);
            n_poll <= n_poll + 1;
          end else if (is_dat) begin
            n_dacc <= n_dacc + 1;
            if (n_dacc == 0) first_data_poll <= n_poll;
            if (m_we_o) begin
              dwr_log[n_dwr[5:0]] <= m_dat_o;
              n_dwr <= n_dwr + 1;
            end else begin
              m_rdat <= DSRC + n_drd;
              n_drd  <= n_drd + 1;
            end
          end else if (m_we_o) begin
            mwr_adr[n_mwr[5:0]] <= m_adr_o;
            mwr_dat[n_mwr[5:0]] <= m_dat_o;
            n_mwr <= n_mwr + 1;
          end else begin
            m_rdat <= memval(m_adr_o);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic cpu_acc(input logic we, input logic [3:0] a, input logic [31:0] d,
                         output logic [31:0] rd);
    @(negedge clk);
    s_adr = 32'h8000_0000 | {28'h0, a};
    s_dat = d; s_we = we; s_stb = 1'b1; s_cyc = 1'b1;
    @(negedge clk);
    check("s_ack", {31'h0, s_ack_o}, 32'h1);
    rd = s_dat_o;
    s_stb = 1'b0; s_cyc = 1'b0; s_we = 1'b0; s_dat = '0;
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rd;
    cpu_acc(1'b1, a, d, rd);
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [31:0] rd);
    cpu_acc(1'b0, a, 32'h0, rd);
  endtask

  task automatic clear_logs;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic wait_job;
    logic [31:0] rd;
    bit          idle = 1'b0;
    for (int unsigned k = 0; k < 1000 && !idle; k++) begin
      cpu_rd(DMA_CTRL, rd);
      idle = !rd[DMA_BUSY];
    end
    if (!idle) check("job_timeout", 32'h1, 32'h0);
  endtask

  task automatic start_job(input logic dirv, input logic irqen, input logic [15:0] n,
                           input logic [31:0] ma);
    cpu_wr(DMA_CTRL, 32'h0000_0600);
    clear_logs();
    cpu_wr(DMA_MADDR, ma);
    cpu_wr(DMA_WCNT, {16'h0, n});
    cpu_wr(DMA_CTRL, {29'h0, irqen, dirv, 1'b1});
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        tab [12];
    logic [31:0] rd;
    bit          found;

    repeat (3) @(negedge clk);
    check("rst_stb", {31'h0, m_stb_o}, 32'h0);
    check("rst_cyc", {31'h0, m_cyc_o}, 32'h0);
    check("rst_we",  {31'h0, m_we_o},  32'h0);
    check("rst_sel", {28'h0, m_sel_o}, 32'hF);
    check("rst_irq", {31'h0, irq_o},   32'h0);
    check("rst_ack", {31'h0, s_ack_o}, 32'h0);
    rst = 1'b0;
    clr = 1'b0;

    // register access table (writes must read back 0 on s_dat_o)
    tab[0]  = '{1'b0, DMA_CTRL,  32'h0,         32'h0};
    tab[1]  = '{1'b0, DMA_MADDR, 32'h0,         32'h0};
    tab[2]  = '{1'b0, DMA_WCNT,  32'h0,         32'h0};
    tab[3]  = '{1'b1, DMA_MADDR, 32'h0000_1237, 32'h0};
    tab[4]  = '{1'b0, DMA_MADDR, 32'h0,         32'h0000_1234};
    tab[5]  = '{1'b1, DMA_WCNT,  32'hABCD_0005, 32'h0};
    tab[6]  = '{1'b0, DMA_WCNT,  32'h0,         32'h0000_0005};
    tab[7]  = '{1'b1, DMA_CTRL,  32'h0000_0706, 32'h0};
    tab[8]  = '{1'b0, DMA_CTRL,  32'h0,         32'h0000_0006};
    tab[9]  = '{1'b0, 4'hC,      32'h0,         32'h0};
    tab[10] = '{1'b1, DMA_CTRL,  32'h0,         32'h0};
    tab[11] = '{1'b0, DMA_CTRL,  32'h0,         32'h0};
    for (int unsigned i = 0; i < 12; i++) begin
      cpu_acc(tab[i].we, tab[i].adr, tab[i].dat, rd);
      check($sformatf("vec%0d", i), rd, tab[i].exp);
    end

    // card->mem, 4 words at 0x100, flag always set
    lat = 1; data_lat = 1; low_polls = 0;
    start_job(1'b0, 1'b1, 16'd4, 32'h100);
    wait_job();
    check("a_drd", n_drd, 4);
    check("a_mwr", n_mwr, 4);
    for (int unsigned i = 0; i < 4; i++) begin
      check($sformatf("a_madr%0d", i), mwr_adr[i], 32'h100 + 4 * i);
      check($sformatf("a_mdat%0d", i), mwr_dat[i], DSRC + i);
    end
    cpu_rd(DMA_CTRL, rd);  check("a_ctrl", rd, 32'h0000_0204);
    check("a_irq", {31'h0, irq_o}, 32'h1);
    cpu_rd(DMA_MADDR, rd); check("a_maddr", rd, 32'h110);
    cpu_rd(DMA_WCNT, rd);  check("a_wcnt", rd, 32'h0);

    // mem->card, 2 words, flag low for 5 polls; writes while busy are ignored
    low_polls = 5;
    start_job(1'b1, 1'b0, 16'd2, 32'h200);
    cpu_wr(DMA_MADDR, 32'h0000_9990);
    cpu_wr(DMA_WCNT, 32'h7);
    cpu_wr(DMA_CTRL, 32'h3);
    wait_job();
    check("b_first_poll", first_data_poll, 6);
    check("b_dwr", n_dwr, 2);
    check("b_d0", dwr_log[0], memval(32'h200));
    check("b_d1", dwr_log[1], memval(32'h204));
    check("b_mwr", n_mwr, 0);
    check("b_dacc", n_dacc, 2);
    cpu_rd(DMA_CTRL, rd);  check("b_ctrl", rd, 32'h0000_0202);
    cpu_rd(DMA_MADDR, rd); check("b_maddr", rd, 32'h208);

    // memory write never acked -> timeout
    low_polls = 0; mem_noack = 1'b1;
    start_job(1'b0, 1'b0, 16'd1, 32'h300);
    wait_job();
    cpu_rd(DMA_CTRL, rd); check("c_ctrl", rd, 32'h0000_0400);
    check("c_stb", {31'h0, m_stb_o}, 32'h0);
    check("c_stb_run", stb_run_max, 255);
    check("c_mwr", n_mwr, 0);
    cpu_rd(DMA_WCNT, rd); check("c_wcnt", rd, 32'h1);
    mem_noack = 1'b0;

    // CRC error on poll -> ERR with no DATA traffic
    crc_mode = 1'b1;
    start_job(1'b0, 1'b0, 16'd3, 32'h380);
    wait_job();
    cpu_rd(DMA_CTRL, rd); check("d_ctrl", rd, 32'h0000_0400);
    check("d_dacc", n_dacc, 0);
    check("d_mwr", n_mwr, 0);
    cpu_rd(DMA_WCNT, rd); check("d_wcnt", rd, 32'h3);
    crc_mode = 1'b0;

    // ABORT while a DATA read is pending
    lat = 0; data_lat = 3;
    start_job(1'b0, 1'b0, 16'd4, 32'h400);
    found = 1'b0;
    for (int unsigned k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (m_stb_o && m_adr_o == A_DAT) found = 1'b1;
    end
    check("e_saw_data_rd", {31'h0, found}, 32'h1);
    cpu_wr(DMA_CTRL, 32'h8);
    wait_job();
    cpu_rd(DMA_CTRL, rd);  check("e_ctrl", rd, 32'h0000_0400);
    check("e_drd", n_drd, 1);
    check("e_mwr", n_mwr, 0);
    check("e_stb", {31'h0, m_stb_o}, 32'h0);
    cpu_rd(DMA_WCNT, rd);  check("e_wcnt", rd, 32'h4);
    cpu_rd(DMA_MADDR, rd); check("e_maddr", rd, 32'h400);

    // START with WCNT=0 -> immediate DONE, no bus cycle
    data_lat = 0;
    start_job(1'b0, 1'b1, 16'd0, 32'h500);
    cpu_rd(DMA_CTRL, rd); check("f_ctrl", rd, 32'h0000_0204);
    check("f_cyc", cyc_cycles, 0);
    check("f_irq", {31'h0, irq_o}, 32'h1);
    cpu_wr(DMA_CTRL, 32'h0000_0204);
    @(negedge clk);
    check("f_irq_clr", {31'h0, irq_o}, 32'h0);

    // randomized jobs against a transfer-list model
    for (int unsigned j = 0; j < 8; j++) begin
      logic        dirv;
      logic [15:0] n;
      logic [31:0] ma;
      dirv = 1'($urandom_range(0, 1));
      n    = 16'($urandom_range(1, 6));
      ma   = $urandom_range(0, 32'h0FFF_FFFF) & 32'hFFFF_FFFC;
      if (j == 0) begin ma = 32'hFFFF_FFF8; n = 16'd4; end
      lat = $urandom_range(0, 3); data_lat = $urandom_range(0, 3);
      low_polls = $urandom_range(0, 3);
      start_job(dirv, 1'b0, n, ma);
      wait_job();
      if (dirv) begin
        check($sformatf("r%0d_dwr", j), n_dwr, 32'(n));
        for (int unsigned i = 0; i < 32'(n); i++)
          check($sformatf("r%0d_d%0d", j, i), dwr_log[i], memval(ma + 4 * i));
      end else begin
        check($sformatf("r%0d_mwr", j), n_mwr, 32'(n));
        for (int unsigned i = 0; i < 32'(n); i++) begin
          check($sformatf("r%0d_ma%0d", j, i), mwr_adr[i], ma + 4 * i);
          check($sformatf("r%0d_md%0d", j, i), mwr_dat[i], DSRC + i);
        end
      end
      cpu_rd(DMA_CTRL, rd);  check($sformatf("r%0d_ctrl", j), rd, 32'h200 | {30'h0, dirv, 1'b0});
      cpu_rd(DMA_MADDR, rd); check($sformatf("r%0d_maddr", j), rd, ma + 4 * 32'(n));
      cpu_rd(DMA_WCNT, rd);  check($sformatf("r%0d_wcnt", j), rd, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
